// File: rtl/mem_wait_ctrl.sv
// rtl/mem_wait_ctrl.sv - unified memory stage driving a wait-state SRAM
// Captures one request, issues a single SRAM access, waits, then pulses ready.
module mem_wait_ctrl #(
  parameter int WAIT_STATES = 2,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          fetch,
  input  logic          MemWrite,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] Adr,
  input  logic [31:0]   WriteData,
  output logic          ready,
  output logic          misaligned,
  output logic [31:0]   ReadData,
  output logic          sram_en,
  output logic          sram_we,
  output logic [3:0]    sram_be,
  output logic [AW-3:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t        state, state_nxt;
  size_t         in_size, size_q;
  logic          in_uns, in_mis;
  logic [AW-1:0] adr_q;
  logic [31:0]   wdata_q;
  logic          we_q, uns_q, mis_q;
  logic [2:0]    cnt_q;
  logic          last_wait;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   load_ext;
  logic [3:0]    st_be;
  logic [31:0]   st_data;

  // Fetches and the reserved funct3 codes all behave as word accesses.
  always_comb begin
    in_size = SZ_W;
    if (!fetch) begin
      case (funct3[1:0])
        2'b00:   in_size = SZ_B;
        2'b01:   in_size = SZ_H;
        default: in_size = SZ_W;
      endcase
    end
    in_uns = funct3[2] & ~fetch;
    case (in_size)
      SZ_H:    in_mis = Adr[0];
      SZ_W:    in_mis = |Adr[1:0];
      default: in_mis = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adr_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      size_q  <= SZ_B;
    end else if (state == IDLE && req) begin
      adr_q   <= Adr;
      wdata_q <= WriteData;
      we_q    <= MemWrite & ~fetch;
      uns_q   <= in_uns;
      mis_q   <= in_mis;
      size_q  <= in_size;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 3'd0;
    end else if (state == ISSUE) begin
      cnt_q <= 3'(WAIT_STATES);
    end else if (state == WAIT && cnt_q != 3'd0) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  assign last_wait = (state == WAIT) && (cnt_q == 3'd0);

  always_comb begin
    case (adr_q[1:0])
      2'd0:    ld_byte = sram_rdata[7:0];
      2'd1:    ld_byte = sram_rdata[15:8];
      2'd2:    ld_byte = sram_rdata[23:16];
      default: ld_byte = sram_rdata[31:24];
    endcase
    ld_half = adr_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];
    case (size_q)
      SZ_B:    load_ext = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_H:    load_ext = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_ext = sram_rdata;
    endcase
  end

  // Sub-word stores replicate the datum so every enabled lane sees it.
  always_comb begin
    case (size_q)
      SZ_B: begin
        st_be   = 4'b0001 << adr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      SZ_H: begin
        st_be   = adr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ReadData <= 32'd0;
    end else if (last_wait && !we_q) begin
      ReadData <= load_ext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    misaligned = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = 4'b0000;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = in_mis ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        sram_en   = 1'b1;
        sram_we   = we_q;
        sram_be   = st_be;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        ready      = 1'b1;
        misaligned = mis_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sram_addr  = adr_q[AW-1:2];
  assign sram_wdata = st_data;

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// tb/tb_mem_wait_ctrl.sv - randomized self-checking bench for mem_wait_ctrl
// Two instances (WAIT_STATES 2 and 0) share one behavioural SRAM; sel picks the active one.
module tb_mem_wait_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req = 1'b0;
  logic        fetch = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] adr = 32'd0;
  logic [31:0] wdata_in = 32'd0;
  logic        req0, req2;
  logic [31:0] rdata_m = 32'd0;

  logic        ready0, mis0, en0, we0, ready2, mis2, en2, we2;
  logic [3:0]  be0, be2;
  logic [29:0] addr0, addr2;
  logic [31:0] rd0, rd2, wd0, wd2;

  logic        cur_ready, cur_mis, cur_en, cur_we;
  logic [3:0]  cur_be;
  logic [29:0] cur_addr;
  logic [31:0] cur_rd, cur_wd;
  int          cur_ws;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd [2];

  assign req0 = req & sel;
  assign req2 = req & ~sel;

  mem_wait_ctrl #(.WAIT_STATES(2), .AW(32)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .fetch(fetch), .MemWrite(mem_write),
    .funct3(funct3), .Adr(adr), .WriteData(wdata_in), .ready(ready2),
    .misaligned(mis2), .ReadData(rd2), .sram_en(en2), .sram_we(we2),
    .sram_be(be2), .sram_addr(addr2), .sram_wdata(wd2), .sram_rdata(rdata_m)
  );

  mem_wait_ctrl #(.WAIT_STATES(0), .AW(32)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .fetch(fetch), .MemWrite(mem_write),
    .funct3(funct3), .Adr(adr), .WriteData(wdata_in), .ready(ready0),
    .misaligned(mis0), .ReadData(rd0), .sram_en(en0), .sram_we(we0),
    .sram_be(be0), .sram_addr(addr0), .sram_wdata(wd0), .sram_rdata(rdata_m)
  );

  always_comb begin
    if (sel) begin
      cur_ready = ready0; cur_mis = mis0; cur_en = en0; cur_we = we0;
      cur_be = be0; cur_addr = addr0; cur_rd = rd0; cur_wd = wd0; cur_ws = 0;
    end else begin
      cur_ready = ready2; cur_mis = mis2; cur_en = en2; cur_we = we2;
      cur_be = be2; cur_addr = addr2; cur_rd = rd2; cur_wd = wd2; cur_ws = 2;
    end
  end

  // Behavioural SRAM: read data is valid only in the cycle 1+WS after the strobe.
  logic [31:0] mem [0:1023];
  bit          init_done = 1'b0;
  bit          pend = 1'b0;
  int          dly = 0;
  logic [31:0] pdata = 32'd0;
  logic        poke_en = 1'b0;
  logic [9:0]  poke_idx = 10'd0;
  logic [31:0] poke_val = 32'd0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= $urandom;
      init_done <= 1'b1;
    end
    if (poke_en) mem[poke_idx] <= poke_val;
    if (cur_en && cur_we)
      for (int j = 0; j < 4; j++)
        if (cur_be[j]) mem[cur_addr[9:0]][8*j +: 8] <= cur_wd[8*j +: 8];
    rdata_m <= $urandom;
    if (cur_en && !cur_we) begin
      if (cur_ws == 0) rdata_m <= mem[cur_addr[9:0]];
      else begin
        pend  <= 1'b1;
        dly   <= cur_ws - 1;
        pdata <= mem[cur_addr[9:0]];
      end
    end else if (pend) begin
      if (dly == 0) begin
        rdata_m <= pdata;
        pend    <= 1'b0;
      end else dly <= dly - 1;
    end
  end

  function automatic int acc_size(bit f, logic [2:0] f3);
    if (f) return 4;
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_load(logic [31:0] word, int sz, bit uns, int off);
    logic [63:0] v;
    v = ({32'd0, word} >> (8 * off)) & ((64'd1 << (8 * sz)) - 64'd1);
    if (!uns && sz < 4 && (((v >> (8 * sz - 1)) & 64'd1) == 64'd1))
      v = v - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_be(int sz, int off);
    logic [7:0] m;
    m = 8'(((1 << sz) - 1) << off);
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(logic [31:0] wd, int sz);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = 8'(wd >> (8 * (j % sz)));
    return r;
  endfunction

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = 10'(idx); poke_val = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic run_access(input bit f, input bit w, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            output int lat, output int ens, output logic [3:0] be_s,
                            output logic we_s, output logic [31:0] wd_s,
                            output logic [29:0] addr_s, output logic mis_s,
                            output logic [31:0] rd_s, output bit to);
    @(negedge clk);
    fetch = f; mem_write = w; funct3 = f3; adr = a; wdata_in = wd; req = 1'b1;
    lat = 0; ens = 0; to = 1'b1; be_s = 4'd0; we_s = 1'b0; wd_s = 32'd0;
    addr_s = 30'd0; mis_s = 1'b0; rd_s = 32'd0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req = 1'b0; adr = $urandom; wdata_in = $urandom;
        funct3 = 3'($urandom); mem_write = 1'($urandom); fetch = 1'($urandom);
      end
      if (cur_en) begin
        ens++; be_s = cur_be; we_s = cur_we; wd_s = cur_wd; addr_s = cur_addr;
      end
      if (cur_ready) begin
        lat = i; mis_s = cur_mis; rd_s = cur_rd; to = 1'b0;
        break;
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ready2, mis2, en2, we2, be2, ready0, mis0, en0, we0, be0} !== 12'd0) begin
      errors++; $display("FAIL reset_ctl got %b expected 0", {ready2, mis2, en2, we2, be2, ready0, mis0, en0, we0, be0});
    end
    checks++;
    if (rd2 !== 32'd0 || rd0 !== 32'd0) begin
      errors++; $display("FAIL reset_rd got %h/%h expected 0", rd2, rd0);
    end
  endtask

  task automatic test_fetch();
    int lat, ens; logic [3:0] be_s; logic we_s, mis_s; logic [31:0] wd_s, rd_s;
    logic [29:0] addr_s; bit to;
    sel = 1'b0;
    poke(32'h100 >> 2, 32'h00500093);
    run_access(1'b1, 1'b0, 3'b000, 32'h100, 32'd0, lat, ens, be_s, we_s, wd_s, addr_s, mis_s, rd_s, to);
    checks++; if (to) begin errors++; $display("FAIL fetch_timeout got none expected ready"); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL fetch_latency got %0d expected 5", lat); end
    checks++; if (ens !== 1) begin errors++; $display("FAIL fetch_en got %0d expected 1", ens); end
    checks++; if (mis_s !== 1'b0) begin errors++; $display("FAIL fetch_mis got %b expected 0", mis_s); end
    checks++; if (rd_s !== 32'h00500093) begin errors++; $display("FAIL fetch_rd got %h expected 00500093", rd_s); end
    last_rd[0] = 32'h00500093;
  endtask

  task automatic test_loads();
    int lat, ens; logic [3:0] be_s; logic we_s, mis_s; logic [31:0] wd_s, rd_s;
    logic [29:0] addr_s; bit to;
    logic [2:0]  f3s [3];
    logic [31:0] as [3];
    logic [31:0] exps [3];
    f3s = '{3'b000, 3'b100, 3'b001};
    as = '{32'h203, 32'h203, 32'h202};
    exps = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};
    sel = 1'b0;
    poke(32'h200 >> 2, 32'h80FF1234);
    for (int k = 0; k < 3; k++) begin
      run_access(1'b0, 1'b0, f3s[k], as[k], 32'd0, lat, ens, be_s, we_s, wd_s, addr_s, mis_s, rd_s, to);
      checks++; if (lat !== 5) begin errors++; $display("FAIL load%0d_latency got %0d expected 5", k, lat); end
      checks++; if (rd_s !== exps[k]) begin errors++; $display("FAIL load%0d_rd got %h expected %h", k, rd_s, exps[k]); end
      last_rd[0] = exps[k];
    end
  endtask

  task automatic test_stores();
    int lat, ens; logic [3:0] be_s; logic we_s, mis_s; logic [31:0] wd_s, rd_s;
    logic [29:0] addr_s; bit to;
    sel = 1'b0;
    run_access(1'b0, 1'b1, 3'b000, 32'h101, 32'h000000AB, lat, ens, be_s, we_s, wd_s, addr_s, mis_s, rd_s, to);
    checks++; if (we_s !== 1'b1) begin errors++; $display("FAIL sb_we got %b expected 1", we_s); end
    checks++; if (be_s !== 4'b0010) begin errors++; $display("FAIL sb_be got %b expected 0010", be_s); end
    checks++; if (wd_s !== 32'hABABABAB) begin errors++; $display("FAIL sb_wdata got %h expected abababab", wd_s); end
    checks++; if (rd_s !== last_rd[0]) begin errors++; $display("FAIL sb_rd got %h expected %h", rd_s, last_rd[0]); end
    run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, lat, ens, be_s, we_s, wd_s, addr_s, mis_s, rd_s, to);
    checks++; if (be_s !== 4'b1100) begin errors++; $display("FAIL sh_be got %b expected 1100", be_s); end
    checks++; if (wd_s !== 32'h12341234) begin errors++; $display("FAIL sh_wdata got %h expected 12341234", wd_s); end
    checks++; if (rd_s !== last_rd[0]) begin errors++; $display("FAIL sh_rd got %h expected %h", rd_s, last_rd[0]); end
  endtask

  task automatic test_misaligned();
    int lat, ens; logic [3:0] be_s; logic we_s, mis_s; logic [31:0] wd_s, rd_s;
    logic [29:0] addr_s; bit to;
    sel = 1'b0;
    run_access(1'b0, 1'b0, 3'b010, 32'h102, 32'd0, lat, ens, be_s, we_s, wd_s, addr_s, mis_s, rd_s, to);
    checks++; if (ens !== 0) begin errors++; $display("FAIL mis_en got %0d expected 0", ens); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL mis_latency got %0d expected 1", lat); end
    checks++; if (mis_s !== 1'b1) begin errors++; $display("FAIL mis_flag got %b expected 1", mis_s); end
    checks++; if (rd_s !== last_rd[0]) begin errors++; $display("FAIL mis_rd got %h expected %h", rd_s, last_rd[0]); end
  endtask

  task automatic test_back_to_back();
    int ens;
    int rdy [$];
    logic [31:0] word;
    sel = 1'b1;
    word = $urandom;
    poke(32'h100 >> 2, word);
    @(negedge clk);
    fetch = 1'b1; mem_write = 1'b0; funct3 = 3'b000; adr = 32'h100; req = 1'b1;
    ens = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 9) req = 1'b0;
      if (cur_en) ens++;
      if (cur_ready) rdy.push_back(i);
    end
    checks++; if (ens !== 3) begin errors++; $display("FAIL b2b_en got %0d expected 3", ens); end
    checks++;
    if (rdy.size() != 3 || rdy[0] != 3 || rdy[1] != 7 || rdy[2] != 11) begin
      errors++; $display("FAIL b2b_ready got %p expected '{3,7,11}", rdy);
    end
    checks++; if (cur_rd !== word) begin errors++; $display("FAIL b2b_rd got %h expected %h", cur_rd, word); end
    last_rd[1] = word;
  endtask

  task automatic test_reset_mid();
    int lat, ens, rdys; logic [3:0] be_s; logic we_s, mis_s; logic [31:0] wd_s, rd_s, word;
    logic [29:0] addr_s; bit to;
    sel = 1'b0;
    @(negedge clk);
    fetch = 1'b0; mem_write = 1'b0; funct3 = 3'b010; adr = 32'h300; req = 1'b1;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({ready2, mis2, en2, we2, be2} !== 8'd0 || rd2 !== 32'd0 || addr2 !== 30'd0 || wd2 !== 32'd0) begin
      errors++; $display("FAIL rstmid_outputs got %b %h %h %h expected zeros", {ready2, mis2, en2, we2, be2}, rd2, addr2, wd2);
    end
    @(negedge clk); rst = 1'b1;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    rdys = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cur_ready) rdys++;
    end
    checks++; if (rdys !== 0) begin errors++; $display("FAIL rstmid_ready got %0d expected 0", rdys); end
    word = $urandom;
    poke(32'h300 >> 2, word);
    run_access(1'b0, 1'b0, 3'b010, 32'h300, 32'd0, lat, ens, be_s, we_s, wd_s, addr_s, mis_s, rd_s, to);
    checks++; if (to || lat !== 5) begin errors++; $display("FAIL rstmid_next_latency got %0d expected 5", lat); end
    checks++; if (rd_s !== word) begin errors++; $display("FAIL rstmid_next_rd got %h expected %h", rd_s, word); end
    last_rd[0] = word;
  endtask

  task automatic test_random();
    int lat, ens, sz, off, e_lat; logic [3:0] be_s; logic we_s, mis_s; logic [31:0] wd_s, rd_s;
    logic [29:0] addr_s; bit to, f, w, e_mis; logic [2:0] f3; logic [31:0] a, wd, word, e_rd;
    for (int n = 0; n < 40; n++) begin
      sel = (n % 4 == 3);
      f3 = 3'($urandom_range(0, 7));
      f = ($urandom_range(0, 7) == 0);
      w = !f && 1'($urandom_range(0, 1));
      sz = acc_size(f, f3);
      a = $urandom_range(0, 4095);
      if ($urandom_range(0, 3) != 0) a = a - (a % sz);
      off = a % 4;
      e_mis = (a % sz) != 0;
      wd = $urandom;
      word = mem[a[11:2]];
      e_rd = (e_mis || w) ? last_rd[sel] : exp_load(word, sz, !f && f3[2], off);
      e_lat = e_mis ? 1 : (sel ? 3 : 5);
      run_access(f, w, f3, a, wd, lat, ens, be_s, we_s, wd_s, addr_s, mis_s, rd_s, to);
      checks++;
      if (to) begin
        errors++; $display("FAIL rand%0d_timeout got none expected ready", n);
        continue;
      end
      checks++; if (lat !== e_lat) begin errors++; $display("FAIL rand%0d_latency got %0d expected %0d", n, lat, e_lat); end
      checks++; if (ens !== (e_mis ? 0 : 1)) begin errors++; $display("FAIL rand%0d_en got %0d expected %0d", n, ens, e_mis ? 0 : 1); end
      checks++; if (mis_s !== e_mis) begin errors++; $display("FAIL rand%0d_mis got %b expected %b", n, mis_s, e_mis); end
      checks++; if (rd_s !== e_rd) begin errors++; $display("FAIL rand%0d_rd got %h expected %h", n, rd_s, e_rd); end
      last_rd[sel] = e_rd;
      if (!e_mis) begin
        checks++; if (addr_s !== a[31:2]) begin errors++; $display("FAIL rand%0d_addr got %h expected %h", n, addr_s, a[31:2]); end
        checks++; if (we_s !== w) begin errors++; $display("FAIL rand%0d_we got %b expected %b", n, we_s, w); end
        if (w) begin
          checks++; if (be_s !== exp_be(sz, off)) begin errors++; $display("FAIL rand%0d_be got %b expected %b", n, be_s, exp_be(sz, off)); end
          checks++; if (wd_s !== exp_wdata(wd, sz)) begin errors++; $display("FAIL rand%0d_wdata got %h expected %h", n, wd_s, exp_wdata(wd, sz)); end
        end
      end
    end
  endtask

  initial begin
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    repeat (3) @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_fetch();
    test_loads();
    test_stores();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_wait_ctrl.md
Name: mem_wait_ctrl

Overview:
- Memory-side stage directly downstream of the multi-cycle controller/datapath. It takes the single unified memory request (fetch or data, address selected by AddrSrc) and drives a synchronous SRAM with a parameterised number of wait states.
- Handles RV32I sub-word loads and stores: byte enables, lane steering, and sign/zero extension.
- Returns a registered ReadData (the non-architectural Data register) and a one-cycle ready pulse that the FSM uses to leave its memory-access states.

Parameters:
- WAIT_STATES, 2, extra SRAM read-latency cycles, legal range 0..7.
- AW, 32, byte-address width; SRAM word address is AW-2 bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req  in  1  access request from FSM; level, sampled only in IDLE
- fetch  in  1  1 = instruction fetch (forces word access, funct3 ignored)
- MemWrite  in  1  1 = store, 0 = load/fetch
- funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- Adr  in  AW  byte address
- WriteData  in  32  store data, right-aligned
- ready  out  1  one-cycle completion pulse
- misaligned  out  1  valid with ready; access was rejected
- ReadData  out  32  extended load/fetch result, held until next completed load
- sram_en  out  1  SRAM access strobe, one cycle per access
- sram_we  out  1  SRAM write
- sram_be  out  4  byte-lane enables
- sram_addr  out  AW-2  word address = Adr[AW-1:2]
- sram_wdata  out  32  lane-steered store data
- sram_rdata  in  32  SRAM read word

Behaviour:
- Reset (rst=0, async): state IDLE; ready, misaligned, sram_en, sram_we = 0; sram_be = 0; ReadData = 0; counters and captured request cleared. Reset mid-transaction aborts the access with no ready.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, req=1: capture Adr, WriteData, MemWrite, fetch, funct3.
  - If misaligned (half with Adr[0]=1; word/fetch with Adr[1:0]!=0), go to DONE with no SRAM access.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): sram_en=1, sram_we=MemWrite, sram_be and sram_wdata per size; wait counter loaded with WAIT_STATES. Then go to WAIT.
- WAIT: lasts WAIT_STATES+1 cycles. SRAM contract: rdata is valid in the cycle that is 1+WAIT_STATES cycles after ISSUE. At the end of the last WAIT cycle, loads/fetches register the extended sram_rdata into ReadData. Then go to DONE.
- DONE (1 cycle): ready=1; misaligned=1 only for a rejected access. Always returns to IDLE.
- Latency, req-sampling cycle to ready: WAIT_STATES+3 for a normal access, 1 for a misaligned one.
- Back-to-back: req held high through DONE starts a new transaction on the next IDLE cycle. Minimum spacing is one IDLE cycle between ready and the next ISSUE.
- req is ignored outside IDLE. Adr, WriteData and the other inputs may change after capture without effect.
- Stores: ReadData unchanged.
  - Byte: be = one-hot on Adr[1:0]; the byte is replicated in all 4 lanes.
  - Half: be = 0011 or 1100 by Adr[1]; the half is replicated in both halves.
  - Word: be = 1111.
- Loads: select lane by captured Adr[1:0]. Sign-extend for 000 and 001; zero-extend for 100 and 101. Word and fetch pass through.
- funct3 011, 110, 111: treated as a word access, including the alignment check.
- Misaligned access: sram_en never asserts and ReadData is unchanged.
- sram_en is asserted exactly one cycle per accepted access and is 0 in every other state.

Test Plan:
- WAIT_STATES=2, fetch=1, Adr=0x100, SRAM returns 0x00500093 → single sram_en in ISSUE, ready 5 cycles after req, ReadData=0x00500093, misaligned=0.
- lb Adr=0x203 with word 0x80FF1234 → be irrelevant, ReadData=0xFFFFFF80. Same access with lbu → 0x00000080. lh Adr=0x202 → 0xFFFF80FF.
- sb WriteData=0x000000AB Adr=0x101 → sram_we=1, be=0010, wdata=0xABABABAB. sh Adr=0x102 WriteData=0x1234 → be=1100, wdata=0x12341234. ReadData unchanged.
- lw Adr=0x102 → no sram_en, ready 1 cycle after req with misaligned=1, ReadData unchanged.
- req held high for 3 consecutive accesses at WAIT_STATES=0 → ready every 4 cycles, exactly 3 sram_en pulses.
- rst pulled low during WAIT of a load, then released → no ready, all outputs 0, next req completes normally.
